digit_serial_mac: RTL and testbench

- Parametrised digit-serial big-integer multiply-accumulate engine; next generation of the fixed-width inner-loop multiplier.
- Computes R = A*B (+ C_in) over NUM_DIG cycles, consuming B in DIG_W-bit digits LSB-first, with a carry-save accumulator.
- Optional final carry-propagate pass produces a resolved result.
- Feeds the modular-reduction stage of the big-number datapath. Result is a redundant pair (r0, r1), or resolved r0 with r1 = 0.

---
 rtl/digit_serial_mac_pkg.sv | 28 ++
 rtl/digit_serial_mac_if.sv | 30 +++
 rtl/digit_serial_mac_csa_3to2.sv | 15 +
 rtl/digit_serial_mac.sv | 106 ++++++++++
 tb/tb_digit_serial_mac.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/digit_serial_mac_pkg.sv
// Shared types and elaboration helpers for the digit-serial multiply-accumulate engine.
package digit_serial_mac_pkg;

    localparam int unsigned DEF_A_W   = 3074;
    localparam int unsigned DEF_B_W   = 108;
    localparam int unsigned DEF_DIG_W = 18;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        RES  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int unsigned num_dig(input int unsigned b_w, input int unsigned dig_w);
        return b_w / dig_w;
    endfunction

    function automatic int unsigned res_w(input int unsigned a_w, input int unsigned b_w);
        return a_w + b_w;
    endfunction

    // Counter must be at least one bit wide even for a single-digit multiplier.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_mac_if.sv
// Start/operand/result bundle between the MAC engine and its requester.
interface digit_serial_mac_if
    import digit_serial_mac_pkg::*;
#(
    parameter int unsigned A_W = DEF_A_W,
    parameter int unsigned B_W = DEF_B_W
);
    localparam int unsigned R_W = A_W + B_W;

    logic           i_en;
    logic           i_acc_mode;
    logic [A_W-1:0] i_a;
    logic [B_W-1:0] i_b;
    logic [R_W-1:0] i_c_in;
    logic           o_busy;
    logic           o_en_out;
    logic [R_W-1:0] o_r0;
    logic [R_W-1:0] o_r1;

    modport master (
        output i_en, i_acc_mode, i_a, i_b, i_c_in,
        input  o_busy, o_en_out, o_r0, o_r1
    );

    modport slave (
        input  i_en, i_acc_mode, i_a, i_b, i_c_in,
        output o_busy, o_en_out, o_r0, o_r1
    );

endinterface

// File: rtl/digit_serial_mac_csa_3to2.sv
// Bitwise 3:2 carry-save compressor; the caller applies the carry shift.
module csa_3to2 #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_x,
    input  logic [W-1:0] i_y,
    input  logic [W-1:0] i_z,
    output logic [W-1:0] o_sum,
    output logic [W-1:0] o_carry
);

    assign o_sum   = i_x ^ i_y ^ i_z;
    assign o_carry = (i_x & i_y) | (i_x & i_z) | (i_y & i_z);

endmodule

// File: rtl/digit_serial_mac.sv
// Digit-serial A*B (+C) engine: one DIG_W-bit multiplier digit per cycle into a
// carry-save accumulator, with an optional carry-propagate pass at the end.
module digit_serial_mac
    import digit_serial_mac_pkg::*;
#(
    parameter int unsigned A_W     = DEF_A_W,
    parameter int unsigned B_W     = DEF_B_W,
    parameter int unsigned DIG_W   = DEF_DIG_W,
    parameter int unsigned RESOLVE = 0
) (
    input  logic            clk,
    input  logic            rst,
    digit_serial_mac_if.slave bus
);

    localparam int unsigned NUM_DIG = num_dig(B_W, DIG_W);
    localparam int unsigned R_W     = res_w(A_W, B_W);
    localparam int unsigned CNT_W   = cnt_w(NUM_DIG);

    generate
        if ((B_W % DIG_W) != 0) begin : g_bad_digit
            $error("digit_serial_mac: B_W must be a multiple of DIG_W");
        end
    endgenerate

    state_t             r_state;
    state_t             w_next;
    logic [R_W-1:0]     r_a_sh;
    logic [B_W-1:0]     r_b_sh;
    logic [CNT_W-1:0]   r_cnt;
    logic [R_W-1:0]     r_r0;
    logic [R_W-1:0]     r_r1;

    logic               w_start;
    logic               w_last;
    logic [DIG_W-1:0]   w_digit;
    logic [R_W-1:0]     w_pp;
    logic [R_W-1:0]     w_sum;
    logic [R_W-1:0]     w_carry;

    assign w_start = bus.i_en && ((r_state == IDLE) || (r_state == DONE));
    assign w_last  = (r_cnt == CNT_W'(NUM_DIG - 1));

    // Multiplicand walks left and multiplier walks right each digit, so the
    // current digit is always the low slice and pp is already aligned.
    assign w_digit = r_b_sh[DIG_W-1:0];
    assign w_pp    = r_a_sh * R_W'(w_digit);

    csa_3to2 #(.W(R_W)) u_csa (
        .i_x     (r_r0),
        .i_y     (r_r1),
        .i_z     (w_pp),
        .o_sum   (w_sum),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.i_en) w_next = MAC;
            MAC:     if (w_last) w_next = (RESOLVE != 0) ? RES : DONE;
            RES:     w_next = DONE;
            DONE:    w_next = bus.i_en ? MAC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_cnt  <= '0;
            r_r0   <= '0;
            r_r1   <= '0;
        end else if (w_start) begin
            r_a_sh <= R_W'(bus.i_a);
            r_b_sh <= bus.i_b;
            r_cnt  <= '0;
            r_r0   <= bus.i_acc_mode ? bus.i_c_in : '0;
            r_r1   <= '0;
        end else if (r_state == MAC) begin
            r_a_sh <= r_a_sh << DIG_W;
            r_b_sh <= r_b_sh >> DIG_W;
            r_cnt  <= r_cnt + 1'b1;
            r_r0   <= w_sum;
            r_r1   <= w_carry << 1;
        end else if (r_state == RES) begin
            r_r0   <= r_r0 + r_r1;
            r_r1   <= '0;
        end
    end

    assign bus.o_busy   = (r_state == MAC) || (r_state == RES);
    assign bus.o_en_out = (r_state == DONE);
    assign bus.o_r0     = r_r0;
    assign bus.o_r1     = r_r1;

endmodule

// File: tb/tb_digit_serial_mac.sv
// Bench for digit_serial_mac: directed small-width cases plus randomized
// full-width operations checked against an arithmetic reference.
module tb_digit_serial_mac;
    import digit_serial_mac_pkg::*;

    localparam int unsigned SA_W  = 16;
    localparam int unsigned SB_W  = 8;
    localparam int unsigned SD_W  = 4;
    localparam int unsigned SR_W  = SA_W + SB_W;

    localparam int unsigned BA_W  = DEF_A_W;
    localparam int unsigned BB_W  = DEF_B_W;
    localparam int unsigned BR_W  = BA_W + BB_W;
    localparam int unsigned B_LAT = DEF_B_W / DEF_DIG_W + 0 + 1;
    localparam int unsigned N_OPS = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    digit_serial_mac_if #(.A_W(SA_W), .B_W(SB_W)) bus_s ();
    digit_serial_mac_if #(.A_W(BA_W), .B_W(BB_W)) bus_b ();

    digit_serial_mac #(.A_W(SA_W), .B_W(SB_W), .DIG_W(SD_W), .RESOLVE(1)) u_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s.slave)
    );

    digit_serial_mac #(.A_W(BA_W), .B_W(BB_W), .DIG_W(DEF_DIG_W), .RESOLVE(0)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [BR_W-1:0] rnd_wide();
        logic [BR_W-1:0] v;
        v = '0;
        for (int i = 0; i < int'((BR_W + 31) / 32); i++) v = (v << 32) | BR_W'($urandom);
        return v;
    endfunction

    // Reference state for the full-width engine: an op started on edge s
    // must show en_out (and its result) right after edge s + B_LAT - 1.
    bit              m_have_op = 1'b0;
    int              m_done_edge = 0;
    logic [BR_W-1:0] m_exp_sum = '0;
    logic [BR_W-1:0] m_held_sum = '0;

    always @(negedge clk) begin
        logic            exp_busy;
        logic            exp_done;
        logic [BR_W-1:0] dut_sum;
        dut_sum = bus_b.o_r0 + bus_b.o_r1;
        if (rst) begin
            m_have_op  = 1'b0;
            m_held_sum = '0;
            chk("reset_outputs",
                bus_b.o_r0 == '0 && bus_b.o_r1 == '0 && !bus_b.o_busy && !bus_b.o_en_out,
                {bus_b.o_busy, bus_b.o_en_out, 62'(dut_sum)}, 64'd0);
        end else begin
            exp_busy = m_have_op && (cyc < m_done_edge - 1);
            exp_done = m_have_op && (cyc == m_done_edge - 1);
            chk("busy", bus_b.o_busy == exp_busy, 64'(bus_b.o_busy), 64'(exp_busy));
            chk("en_out", bus_b.o_en_out == exp_done, 64'(bus_b.o_en_out), 64'(exp_done));
            if (exp_done) begin
                chk("result_sum", dut_sum == m_exp_sum, 64'(dut_sum), 64'(m_exp_sum));
                m_held_sum = m_exp_sum;
                m_have_op  = 1'b0;
            end else if (!exp_busy) begin
                chk("hold_sum", dut_sum == m_held_sum, 64'(dut_sum), 64'(m_held_sum));
            end
            if (bus_b.i_en && !exp_busy) begin
                m_have_op   = 1'b1;
                m_done_edge = cyc + 1 + int'(B_LAT);
                m_exp_sum   = BR_W'(bus_b.i_a) * BR_W'(bus_b.i_b)
                            + (bus_b.i_acc_mode ? bus_b.i_c_in : '0);
            end
        end
    end

    task automatic drive_big_random();
        logic [BR_W-1:0] w;
        w = rnd_wide();
        bus_b.i_a = ($urandom_range(0, 19) == 0) ? '0 : BA_W'(w);
        w = rnd_wide();
        bus_b.i_b = ($urandom_range(0, 19) == 0) ? '0 : BB_W'(w);
        bus_b.i_c_in = rnd_wide();
        bus_b.i_acc_mode = 1'($urandom_range(0, 1));
    endtask

    task automatic run_small(input string name, input logic [SA_W-1:0] a, input logic [SB_W-1:0] b,
                             input logic acc, input logic [SR_W-1:0] c, input logic [SR_W-1:0] exp_r0);
        int  lat;
        bit  seen;
        bus_s.i_a = a;
        bus_s.i_b = b;
        bus_s.i_acc_mode = acc;
        bus_s.i_c_in = c;
        bus_s.i_en = 1'b1;
        @(posedge clk); #1;
        bus_s.i_en = 1'b0;
        bus_s.i_a = SA_W'($urandom);
        bus_s.i_b = SB_W'($urandom);
        bus_s.i_c_in = SR_W'($urandom);
        bus_s.i_acc_mode = ~acc;
        seen = 1'b0;
        lat = 0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            seen = bus_s.o_en_out;
        end
        chk({name, "_latency"}, seen && lat == 4, 64'(lat), 64'd4);
        chk({name, "_r0"}, bus_s.o_r0 == exp_r0, 64'(bus_s.o_r0), 64'(exp_r0));
        chk({name, "_r1"}, bus_s.o_r1 == '0, 64'(bus_s.o_r1), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_op();
        drive_big_random();
        bus_b.i_en = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus_b.i_en = 1'b0;
        @(posedge clk); #1;
        bus_b.i_en = 1'b1;
        drive_big_random();
        @(posedge clk); #1;
        bus_b.i_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async_reset_r0", bus_b.o_r0 == '0, 64'(bus_b.o_r0), 64'd0);
        chk("async_reset_r1", bus_b.o_r1 == '0, 64'(bus_b.o_r1), 64'd0);
        chk("async_reset_ctl", !bus_b.o_busy && !bus_b.o_en_out,
            64'({bus_b.o_busy, bus_b.o_en_out}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus_s.i_en = 1'b0; bus_s.i_acc_mode = 1'b0; bus_s.i_a = '0; bus_s.i_b = '0; bus_s.i_c_in = '0;
        bus_b.i_en = 1'b0; bus_b.i_acc_mode = 1'b0; bus_b.i_a = '0; bus_b.i_b = '0; bus_b.i_c_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("small_reset_r0", bus_s.o_r0 == '0, 64'(bus_s.o_r0), 64'd0);
        chk("small_reset_r1", bus_s.o_r1 == '0, 64'(bus_s.o_r1), 64'd0);
        chk("small_reset_ctl", !bus_s.o_busy && !bus_s.o_en_out,
            64'({bus_s.o_busy, bus_s.o_en_out}), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_small("max_noacc", 16'hFFFF, 8'hFF, 1'b0, 24'h000000, 24'hFEFF01);
        run_small("acc_add",   16'h1234, 8'h10, 1'b1, 24'h000005, 24'h012345);
        run_small("acc_wrap",  16'hFFFF, 8'hFF, 1'b1, 24'hFFFFFF, 24'hFEFF00);
        run_small("c_ignored", 16'h0003, 8'h05, 1'b0, 24'hABCDEF, 24'h00000F);
        run_small("zero_a",    16'h0000, 8'h5A, 1'b1, 24'h123456, 24'h123456);

        for (int op = 0; op < int'(N_OPS); op++) begin
            if (op == int'(N_OPS) / 2) reset_mid_op();
            drive_big_random();
            bus_b.i_en = 1'b1;
            @(posedge clk); #1;
            if ($urandom_range(0, 2) == 0) begin
                repeat (B_LAT - 1) begin
                    drive_big_random();
                    bus_b.i_en = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end else begin
                bus_b.i_en = 1'b0;
                drive_big_random();
                repeat (int'(B_LAT) - 1 + int'($urandom_range(0, 3))) begin
                    @(posedge clk); #1;
                end
            end
        end
        bus_b.i_en = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
